// File: rtl/mem_burst_reader.sv
// Burst reader: fetches COUNT consecutive bytes from a one-cycle-latency byte memory
// and streams them out through a small FIFO with a registered valid/ready head.
//
// state | meaning
// IDLE  | waiting for start; zero-length bursts complete here
// RUN   | issuing reads while the buffer has a reserved slot
// DRAIN | all reads issued; waiting for the last byte to be popped
module mem_burst_reader #(
  parameter int ADDR_W     = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W-1:0] count,
  output logic              busy,
  output logic              done,
  output logic              mem_re,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [7:0]        mem_rdata,
  output logic [7:0]        out_data,
  output logic              out_valid,
  input  logic              out_ready
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int OCC_W = $clog2(FIFO_DEPTH + 1);
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(FIFO_DEPTH - 1);
  localparam logic [OCC_W+1:0] DEPTH_L  = (OCC_W + 2)'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  state_t            state, state_n;
  logic [ADDR_W-1:0] addr, remaining, issue_addr;
  logic              rd_pending, issue, load, done_n, push, pop, room;
  logic [OCC_W-1:0]  occ, occ_n, occ_after_pop;
  logic [OCC_W+1:0]  reserved;
  logic [PTR_W-1:0]  rd_ptr, wr_ptr, rd_ptr_n, wr_ptr_n;
  logic [7:0]        buf_mem [FIFO_DEPTH];

  // A slot is reserved for the read on the bus (mem_re) and the one returning (rd_pending);
  // a pop in the same cycle frees a slot, which keeps full throughput at depth 3.
  always_comb begin
    push          = rd_pending;
    pop           = out_valid & out_ready;
    occ_after_pop = occ - OCC_W'(pop);
    occ_n         = occ_after_pop + OCC_W'(push);
    rd_ptr_n      = rd_ptr;
    if (pop) rd_ptr_n = (rd_ptr == LAST_PTR) ? '0 : rd_ptr + PTR_W'(1);
    wr_ptr_n      = wr_ptr;
    if (push) wr_ptr_n = (wr_ptr == LAST_PTR) ? '0 : wr_ptr + PTR_W'(1);
    reserved      = (OCC_W + 2)'(occ) + (OCC_W + 2)'(mem_re) + (OCC_W + 2)'(rd_pending);
    room          = (remaining != '0) && (reserved < DEPTH_L + (OCC_W + 2)'(pop));
  end

  always_comb begin
    state_n    = state;
    issue      = 1'b0;
    issue_addr = addr;
    load       = 1'b0;
    done_n     = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          if (count != '0) begin
            issue      = 1'b1;
            issue_addr = base_addr;
            load       = 1'b1;
            state_n    = (count == ADDR_W'(1)) ? DRAIN : RUN;
          end else begin
            done_n = 1'b1;
          end
        end
      end
      RUN: begin
        if (room) begin
          issue = 1'b1;
          if (remaining == ADDR_W'(1)) state_n = DRAIN;
        end
      end
      DRAIN: begin
        if (!mem_re && !rd_pending && occ_n == '0) begin
          state_n = IDLE;
          done_n  = 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy       <= 1'b0;
      done       <= 1'b0;
      mem_re     <= 1'b0;
      mem_addr   <= '0;
      addr       <= '0;
      remaining  <= '0;
      rd_pending <= 1'b0;
      occ        <= '0;
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      out_valid  <= 1'b0;
      out_data   <= '0;
    end else begin
      busy       <= (state_n != IDLE);
      done       <= done_n;
      mem_re     <= issue;
      rd_pending <= mem_re;
      if (issue) mem_addr <= issue_addr;
      if (load) begin
        addr      <= base_addr + ADDR_W'(1);
        remaining <= count - ADDR_W'(1);
      end else if (issue) begin
        addr      <= addr + ADDR_W'(1);
        remaining <= remaining - ADDR_W'(1);
      end
      occ       <= occ_n;
      rd_ptr    <= rd_ptr_n;
      wr_ptr    <= wr_ptr_n;
      out_valid <= (occ_n != '0);
      // Head register: bypass the returning byte when it becomes the new head.
      if (occ_n != '0) out_data <= (occ_after_pop == '0) ? mem_rdata : buf_mem[rd_ptr_n];
    end
  end

  always_ff @(posedge clk) begin
    if (push) buf_mem[wr_ptr] <= mem_rdata;
  end

endmodule

// File: doc/mem_burst_reader.md
Name: mem_burst_reader

Overview:
- Read-side counterpart to the writable 8-bit register/memory storage.
- On a start command, reads COUNT consecutive bytes from a synchronous byte memory, one-cycle read latency, beginning at a base address.
- Streams the bytes to a consumer over a valid/ready interface.
- Sits between the RSSB data memory and any unit that needs sequential operand or program fetch (loader, debug dump, fetch stage).

Parameters:
- ADDR_W, 8, width of memory address and of the byte-count input.
- FIFO_DEPTH, 4, entries in the internal output buffer. Must be >= 2. A value >= 3 is required for one byte per cycle sustained throughput.

Ports:
- clk  input  1  clock
- rst  input  1  reset, asynchronous, active-high
- start  input  1  begin a burst; sampled only in IDLE
- base_addr  input  ADDR_W  first byte address; latched on accepted start
- count  input  ADDR_W  number of bytes to read; latched on accepted start; 0 is allowed
- busy  output  1  high while a burst is in progress
- done  output  1  one-cycle pulse when a burst completes
- mem_re  output  1  memory read enable
- mem_addr  output  ADDR_W  memory read address
- mem_rdata  input  8  read data; valid in the cycle after a cycle with mem_re=1
- out_data  output  8  head-of-buffer byte
- out_valid  output  1  out_data valid
- out_ready  input  1  consumer accepts out_data

Behaviour:
- Reset (async, any time, including mid-burst): the following clear immediately:
  - state=IDLE; busy=0, done=0, mem_re=0, mem_addr=0, out_valid=0, out_data=0.
  - Buffer emptied; in-flight read discarded.
  - The mem_rdata return following reset deassertion is ignored.
- All outputs are registered; there is no combinational path from out_ready or start to any output.
- FSM states:
  - IDLE: busy=0.
    - start=1 with count!=0: latch base_addr/count, go to RUN.
    - start=1 with count==0: done=1 in the next cycle, remain IDLE, no mem_re.
  - RUN: busy=1.
    - Each cycle where remaining>0 and (occupancy + inflight) < FIFO_DEPTH:
      - Drive mem_re=1 with mem_addr=current address.
      - Increment address modulo 2^ADDR_W; decrement remaining.
    - When the final read is issued, go to DRAIN.
  - DRAIN: busy=1, mem_re=0.
    - When no read is in flight and the buffer empties via a final pop, go to IDLE.
    - done=1 for exactly the first IDLE cycle. busy=0 in that cycle.
- Latency: with start sampled at edge E:
  - First mem_re is high in cycle E+1.
  - mem_rdata is captured into the buffer at edge E+2.
  - out_valid=1 from E+2.
  - With out_ready=1 and FIFO_DEPTH>=3, bytes emerge on consecutive cycles.
- inflight is 0 or 1: it is set by mem_re and cleared when data is written into the buffer on the following edge.
- Issue rule guarantees returned data always has a buffer slot. Overflow is impossible; the bench asserts this.
- Buffer:
  - FIFO order preserved.
  - Push and pop in the same cycle are legal when full or when holding one entry.
  - out_data holds its value while out_valid=1 and out_ready=0.
  - out_data value is don't-care-stable (holds last) when empty.
- out_valid=1 && out_ready=1 pops one byte.
- start while busy is ignored, with no effect on latched values.
- start in the done cycle is accepted (state is IDLE).
- Address wrap: base_addr + k is taken modulo 2^ADDR_W, with no error.
- count is treated as unsigned; the maximum burst is 2^ADDR_W - 1 bytes.

Test Plan:
- Basic burst: memory model returns addr^0xA5; base=0x10, count=4, out_ready=1 → mem_addr 0x10..0x13 on 4 consecutive cycles; out bytes 0xB5,0xB4,0xB7,0xB6 on consecutive cycles, first at E+2; done one cycle after the last pop; busy low from then.
- Zero count: start with count=0 → done=1 exactly one cycle later; mem_re never asserted; busy stays 0.
- Backpressure: count=8, out_ready=0 for 10 cycles then 1 → exactly FIFO_DEPTH (4) mem_re pulses before the stall; no byte lost or duplicated; 8 bytes in address order; done after the 8th pop.
- Wrap-around: base=0xFE, count=4 → mem_addr sequence 0xFE,0xFF,0x00,0x01; data matches the model.
- Start while busy: second start with base=0x40 during a burst from 0x20, count=3 → ignored; only 0x20..0x22 read; a later start in IDLE reads 0x40 correctly.
- Reset mid-burst: assert rst after 2 of 6 bytes popped → all outputs 0 immediately; after release a new burst base=0x00, count=2 returns only model(0x00), model(0x01), with no stale bytes.
